// File: rtl/pipe_hazard_ctrl_if.sv
// Hazard-control bundle between the pipeline datapath and pipe_hazard_ctrl.
// The datapath side (master) drives stage status and receives the
// stall/flush/bubble controls plus the error flag and performance counters.
interface pipe_hazard_ctrl_if;
  logic [4:0]  D_rs1_index;
  logic [4:0]  D_rs2_index;
  logic        D_use_rs1;
  logic        D_use_rs2;
  logic [4:0]  E_rd_index;
  logic        E_is_load;
  logic        jb;
  logic        M_mem_req;
  logic        M_mem_ready;

  logic        F_stall;
  logic        D_stall;
  logic        E_bubble;
  logic        D_flush;
  logic        M_stall;
  logic        W_bubble;
  logic        mem_err;
  logic [31:0] stall_cnt;
  logic [31:0] flush_cnt;

  modport master (
    output D_rs1_index, D_rs2_index, D_use_rs1, D_use_rs2,
    output E_rd_index, E_is_load, jb, M_mem_req, M_mem_ready,
    input  F_stall, D_stall, E_bubble, D_flush, M_stall, W_bubble,
    input  mem_err, stall_cnt, flush_cnt
  );

  modport slave (
    input  D_rs1_index, D_rs2_index, D_use_rs1, D_use_rs2,
    input  E_rd_index, E_is_load, jb, M_mem_req, M_mem_ready,
    output F_stall, D_stall, E_bubble, D_flush, M_stall, W_bubble,
    output mem_err, stall_cnt, flush_cnt
  );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline hazard controller for a five-stage in-order core.
// Resolves load-use, taken branch/jump and data-memory wait hazards into
// stall/flush/bubble controls. The controls are purely combinational; the
// only state is the memory-wait tracker (RUN/WAIT/ERR with a wait counter),
// a sticky timeout flag and two wrapping performance counters.
module pipe_hazard_ctrl #(
  parameter int unsigned MEM_TIMEOUT = 255
) (
  input  logic          clk,
  input  logic          rst,
  pipe_hazard_ctrl_if.slave hz
);

  localparam logic [1:0] RUN  = 2'd0;
  localparam logic [1:0] WAIT = 2'd1;
  localparam logic [1:0] ERR  = 2'd2;

  localparam logic [9:0] TIMEOUT = 10'(MEM_TIMEOUT);

  logic [1:0]  state;
  logic [9:0]  wcnt;
  logic        mem_err_q;
  logic [31:0] stall_cnt;
  logic [31:0] flush_cnt;

  logic        load_use;
  logic        mem_hold;

  logic        f_stall;
  logic        d_stall;
  logic        e_bubble;
  logic        d_flush;
  logic        m_stall;
  logic        w_bubble;

  // A load in E whose destination is a live source of the D instruction.
  // x0 never carries a dependency, and unused operand fields are ignored.
  function automatic logic is_load_use(
    input logic       e_is_load,
    input logic [4:0] e_rd,
    input logic       use1,
    input logic [4:0] rs1,
    input logic       use2,
    input logic [4:0] rs2
  );
    return e_is_load && (e_rd != 5'd0) &&
           ((use1 && (rs1 == e_rd)) || (use2 && (rs2 == e_rd)));
  endfunction

  // Hazard detection from the current stage status.
  always_comb begin
    load_use = is_load_use(hz.E_is_load, hz.E_rd_index,
                           hz.D_use_rs1, hz.D_rs1_index,
                           hz.D_use_rs2, hz.D_rs2_index);
    mem_hold = hz.M_mem_req & ~hz.M_mem_ready;
  end

  // Control outputs, prioritised ERR > memory hold > branch > load-use.
  // A memory hold freezes everything behind M, so a branch or load-use seen
  // during the hold is simply re-evaluated on the cycle the hold releases.
  always_comb begin
    f_stall  = 1'b0;
    d_stall  = 1'b0;
    e_bubble = 1'b0;
    d_flush  = 1'b0;
    m_stall  = 1'b0;
    w_bubble = 1'b0;
    if (rst) begin
      if (state == ERR || mem_hold) begin
        f_stall  = 1'b1;
        d_stall  = 1'b1;
        m_stall  = 1'b1;
        w_bubble = 1'b1;
      end else if (hz.jb) begin
        d_flush  = 1'b1;
        e_bubble = 1'b1;
      end else if (load_use) begin
        f_stall  = 1'b1;
        d_stall  = 1'b1;
        e_bubble = 1'b1;
      end
    end
  end

  // Memory-wait tracker. wcnt counts cycles spent in WAIT; holding past
  // MEM_TIMEOUT wait cycles parks the controller in ERR until reset.
  // Leaving WAIT happens whenever the hold is gone (normally M_mem_ready).
  always_ff @(posedge clk) begin
    if (!rst) begin
      state     <= RUN;
      wcnt      <= 10'd0;
      mem_err_q <= 1'b0;
    end else begin
      case (state)
        RUN: begin
          if (mem_hold) begin
            state <= WAIT;
            wcnt  <= 10'd1;
          end
        end
        WAIT: begin
          if (!mem_hold) begin
            state <= RUN;
            wcnt  <= 10'd0;
          end else if (wcnt == TIMEOUT) begin
            state     <= ERR;
            mem_err_q <= 1'b1;
          end else begin
            wcnt <= wcnt + 10'd1;
          end
        end
        ERR: begin
          state <= ERR;
        end
        default: begin
          state <= RUN;
          wcnt  <= 10'd0;
        end
      endcase
    end
  end

  // Performance counters; both wrap silently at 2^32.
  always_ff @(posedge clk) begin
    if (!rst) begin
      stall_cnt <= 32'd0;
      flush_cnt <= 32'd0;
    end else begin
      stall_cnt <= stall_cnt + {31'd0, f_stall};
      flush_cnt <= flush_cnt + {31'd0, d_flush};
    end
  end

  assign hz.F_stall   = f_stall;
  assign hz.D_stall   = d_stall;
  assign hz.E_bubble  = e_bubble;
  assign hz.D_flush   = d_flush;
  assign hz.M_stall   = m_stall;
  assign hz.W_bubble  = w_bubble;
  assign hz.mem_err   = mem_err_q;
  assign hz.stall_cnt = stall_cnt;
  assign hz.flush_cnt = flush_cnt;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Bench for pipe_hazard_ctrl: directed hazard scenarios followed by a
// randomized run, all checked cycle by cycle against a behavioural model.
module tb_pipe_hazard_ctrl;

  localparam int unsigned TMO = 4;

  logic clk;
  logic rst;

  pipe_hazard_ctrl_if hz();

  pipe_hazard_ctrl #(.MEM_TIMEOUT(TMO)) dut (
    .clk (clk),
    .rst (rst),
    .hz  (hz)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Behavioural model state: consecutive memory-hold cycles seen,
  // error latch and counters.
  int unsigned m_hold_run = 0;
  bit          m_err      = 1'b0;
  logic [31:0] m_stall_cnt = 32'd0;
  logic [31:0] m_flush_cnt = 32'd0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic drive(input logic [4:0] rs1, input logic [4:0] rs2,
                       input logic u1, input logic u2,
                       input logic [4:0] rd, input logic ld,
                       input logic j, input logic rq, input logic rdy);
    hz.D_rs1_index = rs1;
    hz.D_rs2_index = rs2;
    hz.D_use_rs1   = u1;
    hz.D_use_rs2   = u2;
    hz.E_rd_index  = rd;
    hz.E_is_load   = ld;
    hz.jb          = j;
    hz.M_mem_req   = rq;
    hz.M_mem_ready = rdy;
  endtask

  task automatic idle();
    drive(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  // One clock cycle: inputs are already applied (after a falling edge);
  // check controls and counters, then advance the model across the edge.
  task automatic step();
    bit lu, hold, f, d, e, df, m, w;
    #2;
    lu = hz.E_is_load && (hz.E_rd_index != 5'd0) &&
         ((hz.D_use_rs1 && hz.D_rs1_index == hz.E_rd_index) ||
          (hz.D_use_rs2 && hz.D_rs2_index == hz.E_rd_index));
    hold = hz.M_mem_req && !hz.M_mem_ready;
    {f, d, e, df, m, w} = 6'b0;
    if (rst) begin
      if (m_err || hold) {f, d, m, w} = 4'b1111;
      else if (hz.jb)    {df, e} = 2'b11;
      else if (lu)       {f, d, e} = 3'b111;
    end
    chk("ctl", 32'({hz.F_stall, hz.D_stall, hz.E_bubble, hz.D_flush, hz.M_stall, hz.W_bubble}),
        32'({f, d, e, df, m, w}));
    chk("mem_err", 32'(hz.mem_err), 32'(m_err));
    chk("stall_cnt", hz.stall_cnt, m_stall_cnt);
    chk("flush_cnt", hz.flush_cnt, m_flush_cnt);
    @(posedge clk);
    if (!rst) begin
      m_hold_run  = 0;
      m_err       = 1'b0;
      m_stall_cnt = 32'd0;
      m_flush_cnt = 32'd0;
    end else begin
      m_stall_cnt = m_stall_cnt + 32'(f);
      m_flush_cnt = m_flush_cnt + 32'(df);
      if (!m_err) begin
        if (hold) begin
          m_hold_run++;
          // One hold cycle in RUN plus TMO cycles in WAIT are tolerated.
          if (m_hold_run > TMO) m_err = 1'b1;
        end else begin
          m_hold_run = 0;
        end
      end
    end
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b0;
    step();
    step();
    rst = 1'b1;
  endtask

  initial begin
    rst = 1'b0;
    idle();
    @(negedge clk);
    hz.M_mem_ready = 1'b1;
    do_reset();
    chk("reset_stall_cnt", hz.stall_cnt, 32'd0);
    chk("reset_mem_err", 32'(hz.mem_err), 32'd0);

    // Single-cycle load-use on rs2.
    drive(5'd1, 5'd5, 1'b0, 1'b1, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0);
    #2;
    chk("lu_ctl", 32'({hz.F_stall, hz.D_stall, hz.E_bubble}), 32'h7);
    step();
    idle();
    step();
    chk("lu_stall_cnt", hz.stall_cnt, 32'd1);

    // x0 destination and unused operand: no stall.
    do_reset();
    drive(5'd0, 5'd3, 1'b1, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0);
    step();
    drive(5'd7, 5'd3, 1'b0, 1'b0, 5'd7, 1'b1, 1'b0, 1'b0, 1'b0);
    step();
    idle();
    step();
    chk("x0_stall_cnt", hz.stall_cnt, 32'd0);

    // Branch and load-use together: branch wins.
    do_reset();
    drive(5'd9, 5'd0, 1'b1, 1'b0, 5'd9, 1'b1, 1'b1, 1'b0, 1'b0);
    #2;
    chk("jb_lu_ctl", 32'({hz.D_flush, hz.E_bubble, hz.F_stall}), 32'h6);
    step();
    idle();
    step();
    chk("jb_lu_flush_cnt", hz.flush_cnt, 32'd1);
    chk("jb_lu_stall_cnt", hz.stall_cnt, 32'd0);

    // Three-cycle memory wait, branch pending during the wait.
    do_reset();
    drive(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0);
    step();
    hz.jb = 1'b1;
    step();
    step();
    hz.M_mem_ready = 1'b1;
    #2;
    chk("wait_release_flush", 32'(hz.D_flush), 32'd1);
    step();
    idle();
    step();
    chk("wait_stall_cnt", hz.stall_cnt, 32'd3);
    chk("wait_flush_cnt", hz.flush_cnt, 32'd1);

    // Timeout into ERR, ready has no effect, reset recovers.
    do_reset();
    drive(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 5; i++) step();
    chk("tmo_mem_err", 32'(hz.mem_err), 32'd1);
    hz.M_mem_ready = 1'b1;
    hz.jb = 1'b1;
    #2;
    chk("err_ctl", 32'({hz.F_stall, hz.D_stall, hz.M_stall, hz.W_bubble, hz.D_flush}), 32'h1e);
    step();
    step();
    do_reset();
    chk("err_cleared", 32'(hz.mem_err), 32'd0);
    idle();
    hz.jb = 1'b1;
    #2;
    chk("run_after_reset", 32'(hz.D_flush), 32'd1);
    step();

    // Counter wrap.
    idle();
    force dut.stall_cnt = 32'hFFFF_FFFF;
    #1;
    release dut.stall_cnt;
    m_stall_cnt = 32'hFFFF_FFFF;
    drive(5'd4, 5'd0, 1'b1, 1'b0, 5'd4, 1'b1, 1'b0, 1'b0, 1'b0);
    step();
    chk("wrap_stall_cnt", hz.stall_cnt, 32'd0);
    idle();
    step();

    // Randomized traffic with occasional resets.
    for (int i = 0; i < 3000; i++) begin
      drive(5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
            1'($urandom), 1'($urandom),
            5'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
            1'($urandom_range(0, 3) == 0),
            1'($urandom_range(0, 2) != 0),
            1'($urandom_range(0, 3) == 0));
      rst = ($urandom_range(0, 150) != 0);
      step();
    end
    rst = 1'b1;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
